// File: rtl/alu_serial_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_serial_ctrl_if
//  Description : Request/response bundle for the bit-serial ALU controller.
//                The ovf signal exists only when ALU_SERIAL_OVF_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_serial_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
`ifdef ALU_SERIAL_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, op, a, b,
        input  busy, done, result, carry, zero
`ifdef ALU_SERIAL_OVF_EN
        , ovf
`endif
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, carry, zero
`ifdef ALU_SERIAL_OVF_EN
        , ovf
`endif
    );
endinterface
`default_nettype wire

// File: rtl/alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_serial_ctrl
//  Description : Bit-serial ALU, one result bit per clock (LSB first) through
//                a single-bit slice with a fed-back carry register.
//                Optional signed-overflow output under macro ALU_SERIAL_OVF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    alu_serial_ctrl_if.slave bus
);
    localparam int c_IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(WIDTH - 1);

    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_SUB  = 3'b001;
    localparam logic [2:0] c_OP_OR   = 3'b010;
    localparam logic [2:0] c_OP_ORN  = 3'b011;
    localparam logic [2:0] c_OP_AND  = 3'b100;
    localparam logic [2:0] c_OP_ANDN = 3'b101;
    localparam logic [2:0] c_OP_NOT  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state_q, w_state_d;
    logic [c_IDX_W-1:0] r_idx_q, w_idx_d;
    logic [2:0]         r_op_q, w_op_d;
    logic [WIDTH-1:0]   r_a_q, w_a_d;
    logic [WIDTH-1:0]   r_b_q, w_b_d;
    logic               r_c_q, w_c_d;
    logic [WIDTH-1:0]   r_sr_q, w_sr_d;
    logic [WIDTH-1:0]   r_result_q, w_result_d;
    logic               r_carry_q, w_carry_d;
    logic               r_zero_q, w_zero_d;
    logic               r_ovf_q, w_ovf_d;

    logic               w_arith;
    logic               w_b_eff;
    logic               w_sum;
    logic               w_c_next;
    logic               w_logic_bit;
    logic               w_bit;
    logic [WIDTH-1:0]   w_sr_next;

    // Single-bit slice: operands are shifted right so bit 0 is always current.
    always_comb begin
        w_arith  = (r_op_q == c_OP_ADD) || (r_op_q == c_OP_SUB);
        w_b_eff  = (r_op_q == c_OP_SUB) ? ~r_b_q[0] : r_b_q[0];
        w_sum    = r_a_q[0] ^ w_b_eff ^ r_c_q;
        w_c_next = (r_a_q[0] & w_b_eff) | (r_a_q[0] & r_c_q) | (w_b_eff & r_c_q);
        case (r_op_q)
            c_OP_OR:   w_logic_bit = r_a_q[0] | r_b_q[0];
            c_OP_ORN:  w_logic_bit = r_a_q[0] | ~r_b_q[0];
            c_OP_AND:  w_logic_bit = r_a_q[0] & r_b_q[0];
            c_OP_ANDN: w_logic_bit = r_a_q[0] & ~r_b_q[0];
            c_OP_NOT:  w_logic_bit = ~r_a_q[0];
            default:   w_logic_bit = r_a_q[0] ^ r_b_q[0];
        endcase
        w_bit     = w_arith ? w_sum : w_logic_bit;
        w_sr_next = {w_bit, r_sr_q[WIDTH-1:1]};
    end

    always_comb begin
        w_state_d  = r_state_q;
        w_idx_d    = r_idx_q;
        w_op_d     = r_op_q;
        w_a_d      = r_a_q;
        w_b_d      = r_b_q;
        w_c_d      = r_c_q;
        w_sr_d     = r_sr_q;
        w_result_d = r_result_q;
        w_carry_d  = r_carry_q;
        w_zero_d   = r_zero_q;
        w_ovf_d    = r_ovf_q;
        case (r_state_q)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_d = S_RUN;
                    w_idx_d   = '0;
                    w_op_d    = bus.op;
                    w_a_d     = bus.a;
                    w_b_d     = bus.b;
                    w_c_d     = (bus.op == c_OP_SUB);
                    w_sr_d    = '0;
                end
            end
            S_RUN: begin
                w_a_d  = r_a_q >> 1;
                w_b_d  = r_b_q >> 1;
                w_sr_d = w_sr_next;
                w_c_d  = w_arith ? w_c_next : 1'b0;
                if (r_idx_q == c_LAST) begin
                    w_state_d  = S_DONE;
                    w_idx_d    = '0;
                    w_result_d = w_sr_next;
                    w_carry_d  = w_arith ? w_c_next : 1'b0;
                    w_zero_d   = (w_sr_next == '0);
                    // r_c_q here is the carry into the MSB.
                    w_ovf_d    = w_arith ? (r_c_q ^ w_c_next) : 1'b0;
                end else begin
                    w_idx_d = r_idx_q + 1'b1;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q  <= S_IDLE;
            r_idx_q    <= '0;
            r_op_q     <= '0;
            r_a_q      <= '0;
            r_b_q      <= '0;
            r_c_q      <= 1'b0;
            r_sr_q     <= '0;
            r_result_q <= '0;
            r_carry_q  <= 1'b0;
            r_zero_q   <= 1'b1;
            r_ovf_q    <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_idx_q    <= w_idx_d;
            r_op_q     <= w_op_d;
            r_a_q      <= w_a_d;
            r_b_q      <= w_b_d;
            r_c_q      <= w_c_d;
            r_sr_q     <= w_sr_d;
            r_result_q <= w_result_d;
            r_carry_q  <= w_carry_d;
            r_zero_q   <= w_zero_d;
            r_ovf_q    <= w_ovf_d;
        end
    end

    assign bus.busy   = (r_state_q == S_RUN);
    assign bus.done   = (r_state_q == S_DONE);
    assign bus.result = r_result_q;
    assign bus.carry  = r_carry_q;
    assign bus.zero   = r_zero_q;
`ifdef ALU_SERIAL_OVF_EN
    assign bus.ovf    = r_ovf_q;
`else
    logic w_ovf_unused;
    assign w_ovf_unused = r_ovf_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_serial_ctrl
//  Description : Scoreboard bench for alu_serial_ctrl (WIDTH=8), directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_serial_ctrl;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         v;
        int           cyc;
        string        name;
    } exp_t;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         v;
        string        name;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    alu_serial_ctrl_if #(.WIDTH(W)) bus ();

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_result"}, 32'(bus.result), 32'(e.res));
                chk({e.name, "_carry"}, 32'(bus.carry), 32'(e.c));
                chk({e.name, "_zero"}, 32'(bus.zero), 32'(e.z));
                chk({e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
`ifdef ALU_SERIAL_OVF_EN
                chk({e.name, "_ovf"}, 32'(bus.ovf), 32'(e.v));
`endif
            end
        end
    end

    function automatic exp_t mk(input vec_t v, input int k);
        exp_t e;
        e.res = v.res; e.c = v.c; e.z = v.z; e.v = v.v;
        e.cyc = k + W; e.name = v.name;
        return e;
    endfunction

    // One operation; optionally pulse start with junk operands in RUN cycle 3.
    task automatic run_op(input vec_t v, input bit inject);
        int  k;
        int  nb;
        bit  seen;
        @(negedge clk);
        bus.start = 1'b1; bus.op = v.op; bus.a = v.a; bus.b = v.b;
        @(posedge clk);
        #1;
        k = cyc;
        sb.push_back(mk(v, k));
        nb = 0;
        seen = 1'b0;
        for (int n = 0; n < 4 * W; n++) begin
            @(negedge clk);
            if (n == 0) bus.start = 1'b0;
            if (bus.busy) nb++;
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (inject && n == 2) begin
                bus.start = 1'b1; bus.op = 3'b111; bus.a = 8'hAA; bus.b = 8'h55;
            end
            if (inject && n == 3) begin
                bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'hFF;
            end
        end
        if (!seen) chk({v.name, "_timeout"}, 32'd1, 32'd0);
        chk({v.name, "_busy_cycles"}, 32'(nb), 32'(W));
        #1;
        chk({v.name, "_sb_drained"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    vec_t vecs[$];

    function automatic vec_t V(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] r, input logic c, input logic z,
                               input logic v, input string name);
        vec_t x;
        x.op = op; x.a = a; x.b = b; x.res = r; x.c = c; x.z = z; x.v = v; x.name = name;
        return x;
    endfunction

    initial begin
        vec_t t;
        int   k;
        bus.start = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_carry", 32'(bus.carry), 32'd0);
        chk("rst_zero", 32'(bus.zero), 32'd1);
`ifdef ALU_SERIAL_OVF_EN
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
        rst = 1'b0;

        vecs.push_back(V(3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, "add_ff_01"));
        vecs.push_back(V(3'b001, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0, "sub_05_07"));
        vecs.push_back(V(3'b001, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0, 1'b0, "sub_07_05"));
        vecs.push_back(V(3'b010, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0, "or"));
        vecs.push_back(V(3'b011, 8'hF0, 8'h3C, 8'hF3, 1'b0, 1'b0, 1'b0, "orn"));
        vecs.push_back(V(3'b100, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, "and"));
        vecs.push_back(V(3'b101, 8'hF0, 8'h3C, 8'hC0, 1'b0, 1'b0, 1'b0, "andn"));
        vecs.push_back(V(3'b110, 8'hF0, 8'h3C, 8'h0F, 1'b0, 1'b0, 1'b0, "not"));
        vecs.push_back(V(3'b111, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0, 1'b0, "xor"));
        vecs.push_back(V(3'b100, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b1, 1'b0, "and_zero"));
        vecs.push_back(V(3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, "add_7f_01"));
        vecs.push_back(V(3'b001, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1, "sub_80_01"));
        vecs.push_back(V(3'b000, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, "add_01_01"));
        foreach (vecs[i]) run_op(vecs[i], 1'b0);

        // Start pulse during RUN must be ignored.
        run_op(V(3'b001, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0, 1'b0, "sub_ignore"), 1'b1);

        // Reset in RUN cycle 4 abandons the operation with no done pulse.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b000; bus.a = 8'hFF; bus.b = 8'hFF;
        @(posedge clk);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (n == 0) bus.start = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_result", 32'(bus.result), 32'd0);
        chk("midrst_carry", 32'(bus.carry), 32'd0);
        chk("midrst_zero", 32'(bus.zero), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 4) @(negedge clk);
        run_op(V(3'b000, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, "add_after_rst"), 1'b0);

        // Start held high: re-accepted in the first IDLE cycle after DONE.
        t = V(3'b000, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, "b2b");
        @(negedge clk);
        bus.start = 1'b1; bus.op = t.op; bus.a = t.a; bus.b = t.b;
        @(posedge clk);
        #1;
        k = cyc;
        sb.push_back(mk(t, k));
        sb.push_back(mk(t, k + W + 2));
        repeat (W + 2) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int n = 0; n < 4 * W && sb.size() != 0; n++) @(negedge clk);
        #1;
        chk("b2b_sb_drained", 32'(sb.size()), 32'd0);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
